// File: rtl/xs3_gray_pkg.sv
// xs3_gray_pkg: excess-3 Gray digit codes, validity check and scan state encoding
package xs3_gray_pkg;
  localparam logic [3:0] XS3G_D0 = 4'b0010;
  localparam logic [3:0] XS3G_D1 = 4'b0110;
  localparam logic [3:0] XS3G_D2 = 4'b0111;
  localparam logic [3:0] XS3G_D3 = 4'b0101;
  localparam logic [3:0] XS3G_D4 = 4'b0100;
  localparam logic [3:0] XS3G_D5 = 4'b1100;
  localparam logic [3:0] XS3G_D6 = 4'b1101;
  localparam logic [3:0] XS3G_D7 = 4'b1111;
  localparam logic [3:0] XS3G_D8 = 4'b1110;
  localparam logic [3:0] XS3G_D9 = 4'b1010;
  localparam logic [3:0] XS3G_BLANK = 4'b0000;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  function automatic logic xs3g_is_valid(input logic [3:0] code);
    return code inside {XS3G_D0, XS3G_D1, XS3G_D2, XS3G_D3, XS3G_D4,
                        XS3G_D5, XS3G_D6, XS3G_D7, XS3G_D8, XS3G_D9};
  endfunction
endpackage

// File: rtl/xs3_gray_digit_bank.sv
// xs3_gray_digit_bank: double-buffered digit code bank with filtered write port and read mux
module xs3_gray_digit_bank
  import xs3_gray_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_code,
  input  logic             commit,
  input  logic [IDX_W-1:0] rd_ptr,
  output logic [3:0]       rd_code,
  output logic             wr_bad
);
  logic [3:0] shadow [NUM_DIGITS];
  logic [3:0] active [NUM_DIGITS];
  logic in_range;
  assign in_range = int'(wr_idx) < NUM_DIGITS;
  assign wr_bad = we && !(in_range && xs3g_is_valid(wr_code));
  assign rd_code = active[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '{default: XS3G_BLANK};
      active <= '{default: XS3G_BLANK};
    end else begin
      if (we && in_range) shadow[wr_idx] <= xs3g_is_valid(wr_code) ? wr_code : XS3G_BLANK;
      if (commit) active <= shadow;
    end
  end
endmodule

// File: rtl/xs3_gray_digit_scan_ctrl.sv
// xs3_gray_digit_scan_ctrl: scans a digit bank onto one shared XS3-Gray decoder with
// blanking gaps, frame-synchronous bank commit and sticky write-error flag
module xs3_gray_digit_scan_ctrl
  import xs3_gray_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL = 1000,
  parameter int BLANK_CYC = 8,
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [3:0]            wr_code,
  input  logic                  err_clr,
  output logic                  d,
  output logic                  c,
  output logic                  b,
  output logic                  a,
  output logic [NUM_DIGITS-1:0] dig_sel_n,
  output logic                  frame,
  output logic                  err
);
  localparam int CNT_W = $clog2((DWELL > BLANK_CYC ? DWELL : BLANK_CYC) + 1);

  state_t st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [3:0] code, rd_code;
  logic last, we, wr_bad;

  assign wr_ready = ~frame;
  assign we = wr_valid & wr_ready;
  assign {d, c, b, a} = code;

  xs3_gray_digit_bank #(.NUM_DIGITS(NUM_DIGITS), .IDX_W(IDX_W)) u_bank (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_idx(wr_idx), .wr_code(wr_code),
    .commit(frame | ~en), .rd_ptr(ptr_n), .rd_code(rd_code), .wr_bad(wr_bad)
  );

  always_comb begin
    last = (st == ST_SHOW) ? cnt == CNT_W'(DWELL - 1) : cnt == CNT_W'(BLANK_CYC - 1);
    st_n = !en ? ST_BLANK : !last ? st : (st == ST_SHOW) ? ST_BLANK : ST_SHOW;
    cnt_n = (!en || last) ? '0 : cnt + 1'b1;
    ptr_n = !en ? '0 : !(last && st == ST_SHOW) ? ptr :
            (ptr == IDX_W'(NUM_DIGITS - 1)) ? '0 : ptr + 1'b1;
  end

  // outputs are registered from the next state so code and enable switch on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_BLANK;
      cnt <= '0;
      ptr <= '0;
      code <= XS3G_BLANK;
      dig_sel_n <= '1;
      frame <= 1'b0;
      err <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      code <= (st_n == ST_SHOW) ? rd_code : XS3G_BLANK;
      dig_sel_n <= (st_n == ST_SHOW) ? ~(NUM_DIGITS'(1) << ptr_n) : '1;
      frame <= st_n == ST_SHOW && ptr_n == IDX_W'(NUM_DIGITS - 1) && cnt_n == CNT_W'(DWELL - 1);
      err <= wr_bad | (err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_xs3_gray_digit_scan_ctrl.sv
// tb_xs3_gray_digit_scan_ctrl: directed scenario bench for the scan controller (4 digits, dwell 4, blank 1)
module tb_xs3_gray_digit_scan_ctrl;
  logic clk = 0, rst_n = 0, en = 0, wr_valid = 0, err_clr = 0;
  logic [1:0] wr_idx = 0;
  logic [3:0] wr_code = 0;
  logic wr_ready, d, c, b, a, frame, err;
  logic [3:0] dig_sel_n, code_o;
  int checks = 0, errors = 0, k = 0;
  logic [3:0] ebank [4];
  logic [3:0] eshadow [4];

  assign code_o = {d, c, b, a};

  xs3_gray_digit_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_code(wr_code), .err_clr(err_clr), .d(d), .c(c), .b(b), .a(a),
    .dig_sel_n(dig_sel_n), .frame(frame), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  // frame of 20 cycles after a restart at k=0: pos%5==0 is blank, otherwise digit pos/5
  function automatic logic [3:0] esel(int t);
    int p = t % 20;
    return (p % 5 == 0) ? 4'hF : ~(4'b0001 << (p / 5));
  endfunction

  function automatic logic [3:0] ecode(int t);
    int p = t % 20;
    return (p % 5 == 0) ? 4'h0 : ebank[p / 5];
  endfunction

  function automatic logic efrm(int t);
    return t % 20 == 19;
  endfunction

  function automatic logic bvalid(logic [3:0] v);
    return v == 4'h2 || v == 4'h6 || v == 4'h7 || v == 4'h5 || v == 4'h4 ||
           v == 4'hC || v == 4'hD || v == 4'hF || v == 4'hE || v == 4'hA;
  endfunction

  task automatic tick;
    if (!en || k % 20 == 19) ebank = eshadow;
    @(negedge clk);
    k++;
  endtask

  task automatic wr(input logic [1:0] i, input logic [3:0] v);
    wr_idx = i;
    wr_code = v;
    wr_valid = 1;
    tick;
    wr_valid = 0;
    eshadow[i] = bvalid(v) ? v : 4'h0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    en = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dig_sel_n, code_o, frame, err, wr_ready} !== {4'hF, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got sel=%b code=%b frame=%b err=%b ready=%b want 1111 0000 0 0 1",
               dig_sel_n, code_o, frame, err, wr_ready);
    end
    rst_n = 1;
    k = 0;
    ebank = '{default: 4'h0};
    eshadow = '{default: 4'h0};
  endtask

  task automatic test_scan;
    while (k < 40) begin
      tick;
      checks++;
      if ({dig_sel_n, code_o, frame, wr_ready} !== {esel(k), ecode(k), efrm(k), !efrm(k)}) begin
        errors++;
        $display("FAIL scan k=%0d: got sel=%b code=%b frame=%b ready=%b want sel=%b code=%b frame=%b",
                 k, dig_sel_n, code_o, frame, wr_ready, esel(k), ecode(k), efrm(k));
      end
    end
  endtask

  task automatic test_write_latency;
    repeat (2) tick;
    wr(0, 4'b0010);
    wr(3, 4'b1010);
    wr(1, 4'b0101);
    wr(2, 4'b1100);
    while (k < 80) begin
      tick;
      checks++;
      if ({dig_sel_n, code_o, frame} !== {esel(k), ecode(k), efrm(k)}) begin
        errors++;
        $display("FAIL latency k=%0d: got sel=%b code=%b frame=%b want sel=%b code=%b frame=%b",
                 k, dig_sel_n, code_o, frame, esel(k), ecode(k), efrm(k));
      end
      if (k == 56 || k == 61 || k == 76) begin
        checks++;
        if ({dig_sel_n, code_o} !== (k == 56 ? 8'b0111_0000 : k == 61 ? 8'b1110_0010 : 8'b0111_1010)) begin
          errors++;
          $display("FAIL latency_vec k=%0d: got sel=%b code=%b", k, dig_sel_n, code_o);
        end
      end
    end
  endtask

  task automatic test_err;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_idle: got %b want 0", err);
    end
    wr(1, 4'b0000);
    wr(2, 4'b1011);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b want 1", err);
    end
    err_clr = 1;
    tick;
    err_clr = 0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: got %b want 0", err);
    end
    err_clr = 1;
    wr(2, 4'b1011);
    err_clr = 0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set_wins: got %b want 1", err);
    end
    while (k < 120) begin
      tick;
      checks++;
      if ({dig_sel_n, code_o} !== {esel(k), ecode(k)}) begin
        errors++;
        $display("FAIL err_scan k=%0d: got sel=%b code=%b want sel=%b code=%b",
                 k, dig_sel_n, code_o, esel(k), ecode(k));
      end
      if (k == 107 || k == 112) begin
        checks++;
        if ({dig_sel_n, code_o} !== (k == 107 ? 8'b1101_0000 : 8'b1011_0000)) begin
          errors++;
          $display("FAIL err_vec k=%0d: got sel=%b code=%b", k, dig_sel_n, code_o);
        end
      end
    end
  endtask

  task automatic test_frame_stall;
    while (k < 139) tick;
    wr_idx = 1;
    wr_code = 4'b0111;
    wr_valid = 1;
    checks++;
    if ({frame, wr_ready} !== 2'b10) begin
      errors++;
      $display("FAIL stall_frame: got frame=%b ready=%b want 1 0", frame, wr_ready);
    end
    tick;
    checks++;
    if ({frame, wr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_after: got frame=%b ready=%b want 0 1", frame, wr_ready);
    end
    tick;
    wr_valid = 0;
    eshadow[1] = 4'b0111;
    while (k < 180) begin
      tick;
      checks++;
      if ({dig_sel_n, code_o} !== {esel(k), ecode(k)}) begin
        errors++;
        $display("FAIL stall_scan k=%0d: got sel=%b code=%b want sel=%b code=%b",
                 k, dig_sel_n, code_o, esel(k), ecode(k));
      end
      if (k == 146 || k == 166) begin
        checks++;
        if ({dig_sel_n, code_o} !== (k == 146 ? 8'b1101_0000 : 8'b1101_0111)) begin
          errors++;
          $display("FAIL stall_vec k=%0d: got sel=%b code=%b", k, dig_sel_n, code_o);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    while (k < 192) tick;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({dig_sel_n, code_o, err} !== {4'hF, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got sel=%b code=%b err=%b want 1111 0000 0", dig_sel_n, code_o, err);
    end
    @(negedge clk);
    rst_n = 1;
    k = 0;
    ebank = '{default: 4'h0};
    eshadow = '{default: 4'h0};
    while (k < 20) begin
      tick;
      checks++;
      if ({dig_sel_n, code_o, frame} !== {esel(k), ecode(k), efrm(k)}) begin
        errors++;
        $display("FAIL reset_scan k=%0d: got sel=%b code=%b frame=%b want sel=%b code=%b frame=%b",
                 k, dig_sel_n, code_o, frame, esel(k), ecode(k), efrm(k));
      end
      if (k == 1 || k == 16) begin
        checks++;
        if ({dig_sel_n, code_o} !== (k == 1 ? 8'b1110_0000 : 8'b0111_0000)) begin
          errors++;
          $display("FAIL reset_vec k=%0d: got sel=%b code=%b", k, dig_sel_n, code_o);
        end
      end
    end
  endtask

  task automatic test_en;
    while (k < 22) tick;
    en = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) wr(1, 4'b0110);
      else tick;
      checks++;
      if ({dig_sel_n, code_o, frame} !== {4'hF, 4'h0, 1'b0}) begin
        errors++;
        $display("FAIL en_off i=%0d: got sel=%b code=%b frame=%b want 1111 0000 0",
                 i, dig_sel_n, code_o, frame);
      end
    end
    en = 1;
    k = 0;
    while (k < 20) begin
      tick;
      checks++;
      if ({dig_sel_n, code_o, frame} !== {esel(k), ecode(k), efrm(k)}) begin
        errors++;
        $display("FAIL en_scan k=%0d: got sel=%b code=%b frame=%b want sel=%b code=%b frame=%b",
                 k, dig_sel_n, code_o, frame, esel(k), ecode(k), efrm(k));
      end
      if (k == 1 || k == 6) begin
        checks++;
        if ({dig_sel_n, code_o} !== (k == 1 ? 8'b1110_0000 : 8'b1101_0110)) begin
          errors++;
          $display("FAIL en_vec k=%0d: got sel=%b code=%b", k, dig_sel_n, code_o);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_write_latency;
    test_err;
    test_frame_stall;
    test_reset_mid;
    test_en;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
